// File: rtl/plate_digit_overlay.sv
// Overlays a committed string of plate digits as 7-segment glyphs on RGB888 video.
// Strings are staged in a shadow buffer and committed on the vsync falling edge.
module plate_digit_overlay #(
  parameter int unsigned NUM_DIGITS = 7,
  parameter int unsigned ORIGIN_X   = 20,
  parameter int unsigned ORIGIN_Y   = 20,
  parameter int unsigned DIG_W      = 16,
  parameter int unsigned DIG_H      = 28,
  parameter int unsigned DIG_GAP    = 6,
  parameter int unsigned SEG_W      = 3,
  parameter logic [23:0] FG_COLOR   = 24'hFF0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_de,
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  input  logic [23:0] i_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [3:0]  wr_digit,
  input  logic        wr_last,
  output logic        pending,
  output logic [23:0] o_data,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de
);

  localparam int unsigned PITCH = DIG_W + DIG_GAP;
  localparam int unsigned HALF  = DIG_H / 2;
  localparam int unsigned G_TOP = HALF - SEG_W / 2;
  localparam logic [3:0]  BLANK = 4'hA;

  typedef enum logic {S_FILL, S_PENDING} state_e;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  shadow_q [NUM_DIGITS];
  logic [3:0]  shadow_d [NUM_DIGITS];
  logic [3:0]  disp_q   [NUM_DIGITS];
  logic [3:0]  disp_d   [NUM_DIGITS];
  logic        vs_q;
  logic        wr_ready_q, pending_q;
  logic        accept_c, vs_fall_c;

  assign accept_c  = wr_valid && wr_ready_q;
  assign vs_fall_c = vs_q && !i_vs;

  // Write-side FSM: fill the shadow buffer, then wait for the frame boundary to commit.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    disp_d   = disp_q;
    unique case (state_q)
      S_FILL: begin
        if (accept_c) begin
          for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == 4'(k)) shadow_d[k] = wr_digit;
          end
          idx_d = idx_q + 4'd1;
          if (wr_last || (idx_q == 4'(NUM_DIGITS - 1))) state_d = S_PENDING;
        end
      end
      S_PENDING: begin
        if (vs_fall_c) begin
          disp_d = shadow_q;
          for (int unsigned k = 0; k < NUM_DIGITS; k++) shadow_d[k] = BLANK;
          idx_d   = '0;
          state_d = S_FILL;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FILL;
      idx_q      <= '0;
      vs_q       <= 1'b0;
      wr_ready_q <= 1'b1;
      pending_q  <= 1'b0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        shadow_q[k] <= BLANK;
        disp_q[k]   <= BLANK;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      vs_q       <= i_vs;
      wr_ready_q <= (state_d == S_FILL);
      pending_q  <= (state_d == S_PENDING);
      shadow_q   <= shadow_d;
      disp_q     <= disp_d;
    end
  end

  assign wr_ready = wr_ready_q;
  assign pending  = pending_q;

  // Stage 1: locate the glyph slot with a compare chain and form glyph-local coordinates.
  logic [11:0] dx_c, dy_c, lx_c;
  logic [3:0]  slot_c;
  logic        box_c;

  always_comb begin
    dx_c   = i_x - 12'(ORIGIN_X);
    dy_c   = i_y - 12'(ORIGIN_Y);
    slot_c = '0;
    for (int unsigned j = 1; j < NUM_DIGITS; j++) begin
      if (dx_c >= 12'(j * PITCH)) slot_c = 4'(j);
    end
    lx_c  = dx_c - 12'(32'(slot_c) * PITCH);
    box_c = i_de && (i_x >= 12'(ORIGIN_X)) && (i_y >= 12'(ORIGIN_Y)) &&
            (lx_c < 12'(DIG_W)) && (dy_c < 12'(DIG_H));
  end

  logic [3:0]  slot_q;
  logic [11:0] lx_q, ly_q, x1_q, y1_q;
  logic        box_q, hs1_q, vs1_q, de1_q;
  logic [23:0] data1_q;

  // Segment set per code, packed as {a,b,c,d,e,f,g}.
  function automatic logic [6:0] seg_map(input logic [3:0] code);
    case (code)
      4'h0:    seg_map = 7'b1111110;
      4'h1:    seg_map = 7'b0110000;
      4'h2:    seg_map = 7'b1101101;
      4'h3:    seg_map = 7'b1111001;
      4'h4:    seg_map = 7'b0110011;
      4'h5:    seg_map = 7'b1011011;
      4'h6:    seg_map = 7'b1011111;
      4'h7:    seg_map = 7'b1110000;
      4'h8:    seg_map = 7'b1111111;
      4'h9:    seg_map = 7'b1111011;
      4'hF:    seg_map = 7'b0000001;
      default: seg_map = 7'b0000000;
    endcase
  endfunction

  // Stage 2: segment coverage test against the committed digit of the pixel's slot.
  logic [3:0] digit_c;
  logic [6:0] segs_c;
  logic       top_c, left_c, right_c, lit_c;

  always_comb begin
    digit_c = BLANK;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (slot_q == 4'(k)) digit_c = disp_q[k];
    end
    segs_c  = seg_map(digit_c);
    top_c   = ly_q < 12'(HALF);
    left_c  = lx_q < 12'(SEG_W);
    right_c = lx_q >= 12'(DIG_W - SEG_W);
    lit_c   = (segs_c[6] && (ly_q < 12'(SEG_W)))                               ||
              (segs_c[5] && right_c && top_c)                                  ||
              (segs_c[4] && right_c && !top_c)                                 ||
              (segs_c[3] && (ly_q >= 12'(DIG_H - SEG_W)))                      ||
              (segs_c[2] && left_c && !top_c)                                  ||
              (segs_c[1] && left_c && top_c)                                   ||
              (segs_c[0] && (ly_q >= 12'(G_TOP)) && (ly_q < 12'(G_TOP + SEG_W)));
  end

  logic [23:0] odata_q;
  logic [11:0] ox_q, oy_q;
  logic        ohs_q, ovs_q, ode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= '0;
      lx_q    <= '0;
      ly_q    <= '0;
      box_q   <= 1'b0;
      data1_q <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      de1_q   <= 1'b0;
      odata_q <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      ohs_q   <= 1'b0;
      ovs_q   <= 1'b0;
      ode_q   <= 1'b0;
    end else begin
      slot_q  <= slot_c;
      lx_q    <= lx_c;
      ly_q    <= dy_c;
      box_q   <= box_c;
      data1_q <= i_data;
      x1_q    <= i_x;
      y1_q    <= i_y;
      hs1_q   <= i_hs;
      vs1_q   <= i_vs;
      de1_q   <= i_de;
      odata_q <= (box_q && lit_c) ? FG_COLOR : data1_q;
      ox_q    <= x1_q;
      oy_q    <= y1_q;
      ohs_q   <= hs1_q;
      ovs_q   <= vs1_q;
      ode_q   <= de1_q;
    end
  end

  assign o_data = odata_q;
  assign o_x    = ox_q;
  assign o_y    = oy_q;
  assign o_hs   = ohs_q;
  assign o_vs   = ovs_q;
  assign o_de   = ode_q;

endmodule

// File: tb/tb_plate_digit_overlay.sv
// Randomized bench for plate_digit_overlay against a glyph-geometry reference model.
module tb_plate_digit_overlay;

  localparam int NUM   = 7;
  localparam int OX    = 20;
  localparam int OY    = 20;
  localparam int DW    = 16;
  localparam int DH    = 28;
  localparam int GAP   = 6;
  localparam int SW    = 3;
  localparam int PITCH = DW + GAP;
  localparam int HH    = DH / 2;
  localparam logic [23:0] FG = 24'hFF0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_hs = 1'b0, i_vs = 1'b0, i_de = 1'b0;
  logic [11:0] i_x = '0, i_y = '0;
  logic [23:0] i_data = '0;
  logic        wr_valid = 1'b0, wr_last = 1'b0;
  logic [3:0]  wr_digit = '0;
  logic        wr_ready, pending;
  logic [23:0] o_data;
  logic [11:0] o_x, o_y;
  logic        o_hs, o_vs, o_de;

  always #5 clk = ~clk;

  plate_digit_overlay dut (
    .clk(clk), .rst_n(rst_n),
    .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_x(i_x), .i_y(i_y), .i_data(i_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_digit(wr_digit), .wr_last(wr_last),
    .pending(pending),
    .o_data(o_data), .o_x(o_x), .o_y(o_y), .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de)
  );

  typedef struct {
    logic [23:0] data;
    logic [11:0] x, y;
    logic        hs, vs, de;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [3:0] m_disp   [NUM];
  logic [3:0] m_shadow [NUM];
  int         m_idx;
  bit         m_ready;
  bit         m_vs_prev;

  function automatic void model_reset();
    for (int k = 0; k < NUM; k++) begin
      m_disp[k]   = 4'hA;
      m_shadow[k] = 4'hA;
    end
    m_idx = 0; m_ready = 1'b1; m_vs_prev = 1'b0;
  endfunction

  function automatic void model_commit();
    if (!m_ready) begin
      for (int k = 0; k < NUM; k++) begin
        m_disp[k]   = m_shadow[k];
        m_shadow[k] = 4'hA;
      end
      m_idx = 0; m_ready = 1'b1;
    end
  endfunction

  function automatic string seg_str(input logic [3:0] d);
    case (d)
      4'h0: return "abcdef";
      4'h1: return "bc";
      4'h2: return "abdeg";
      4'h3: return "abcdg";
      4'h4: return "bcfg";
      4'h5: return "acdfg";
      4'h6: return "acdefg";
      4'h7: return "abc";
      4'h8: return "abcdefg";
      4'h9: return "abcdfg";
      4'hF: return "g";
      default: return "";
    endcase
  endfunction

  function automatic bit covers(input byte c, input int lx, input int ly);
    case (c)
      "a": return ly < SW;
      "b": return (lx >= DW - SW) && (ly < HH);
      "c": return (lx >= DW - SW) && (ly >= HH);
      "d": return ly >= DH - SW;
      "e": return (lx < SW) && (ly >= HH);
      "f": return (lx < SW) && (ly < HH);
      "g": return (ly >= HH - SW / 2) && (ly < HH - SW / 2 + SW);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [23:0] model_pix(input int x, input int y, input bit de, input logic [23:0] d);
    int dx, dy, slot, lx;
    string s;
    dx = x - OX;
    dy = y - OY;
    if (!de || dx < 0 || dy < 0 || dy >= DH) return d;
    slot = dx / PITCH;
    lx   = dx % PITCH;
    if (slot >= NUM || lx >= DW) return d;
    s = seg_str(m_disp[slot]);
    for (int i = 0; i < s.len(); i++) if (covers(s[i], lx, dy)) return FG;
    return d;
  endfunction

  // One pixel per clock; checks the pixel issued two cycles earlier.
  task automatic drive_pixel(input int x, input int y, input bit de, input bit hs, input bit vs,
                             input logic [23:0] d);
    exp_t e;
    @(negedge clk);
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      n_checks++;
      if (o_data !== e.data)
        $display("FAIL pixel_data at (%0d,%0d): got %h, want %h", e.x, e.y, o_data, e.data);
      else n_pass++;
      n_checks++;
      if ({o_x, o_y, o_hs, o_vs, o_de} !== {e.x, e.y, e.hs, e.vs, e.de})
        $display("FAIL pixel_sync: got x=%0d y=%0d hs=%b vs=%b de=%b, want x=%0d y=%0d hs=%b vs=%b de=%b",
                 o_x, o_y, o_hs, o_vs, o_de, e.x, e.y, e.hs, e.vs, e.de);
      else n_pass++;
    end
    n_checks++;
    if ({wr_ready, pending} !== {m_ready, !m_ready})
      $display("FAIL frame_flags: got ready=%b pending=%b, want ready=%b pending=%b",
               wr_ready, pending, m_ready, !m_ready);
    else n_pass++;
    i_x = 12'(x); i_y = 12'(y); i_de = de; i_hs = hs; i_vs = vs; i_data = d;
    if (m_vs_prev && !vs) model_commit();
    m_vs_prev = vs;
    e.data = model_pix(x, y, de, d);
    e.x = 12'(x); e.y = 12'(y); e.hs = hs; e.vs = vs; e.de = de;
    exp_q.push_back(e);
  endtask

  task automatic run_frame(input int n);
    for (int i = 0; i < n; i++)
      drive_pixel($urandom_range(0, OX + NUM * PITCH + 8), $urandom_range(0, OY + DH + 4),
                  $urandom_range(0, 9) != 0, 1'($urandom), 1'b1, 24'($urandom));
    repeat (6) drive_pixel(0, 0, 1'b0, 1'b0, 1'b0, 24'h0);
    exp_q.delete();
  endtask

  task automatic probe(input int x, input int y, input bit lit, input string name);
    logic [23:0] d;
    d = 24'($urandom);
    if (d == FG) d = ~d;
    drive_pixel(x, y, 1'b1, 1'b0, 1'b1, d);
    drive_pixel(0, 0, 1'b0, 1'b0, 1'b1, 24'h0);
    drive_pixel(0, 0, 1'b0, 1'b0, 1'b1, 24'h0);
    n_checks++;
    if (o_data !== (lit ? FG : d))
      $display("FAIL probe_%s: got %h, want %h", name, o_data, lit ? FG : d);
    else n_pass++;
  endtask

  task automatic write_digit(input logic [3:0] d, input bit last);
    @(negedge clk);
    n_checks++;
    if ({wr_ready, pending} !== {m_ready, !m_ready})
      $display("FAIL write_flags: got ready=%b pending=%b, want ready=%b pending=%b",
               wr_ready, pending, m_ready, !m_ready);
    else n_pass++;
    wr_valid = 1'b1; wr_digit = d; wr_last = last;
    if (m_ready) begin
      m_shadow[m_idx] = d;
      m_idx++;
      if (last || m_idx == NUM) m_ready = 1'b0;
    end
  endtask

  task automatic write_idle();
    @(negedge clk);
    n_checks++;
    if ({wr_ready, pending} !== {m_ready, !m_ready})
      $display("FAIL idle_flags: got ready=%b pending=%b, want ready=%b pending=%b",
               wr_ready, pending, m_ready, !m_ready);
    else n_pass++;
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({o_data, o_x, o_y, o_hs, o_vs, o_de} !== '0 || wr_ready !== 1'b1 || pending !== 1'b0)
      $display("FAIL reset_state: got data=%h x=%0d y=%0d ready=%b pending=%b, want zeros ready=1 pending=0",
               o_data, o_x, o_y, wr_ready, pending);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (wr_ready !== 1'b1 || pending !== 1'b0)
      $display("FAIL reset_release: got ready=%b pending=%b, want 1 0", wr_ready, pending);
    else n_pass++;
  endtask

  task automatic test_passthrough();
    run_frame(150);
  endtask

  task automatic test_commit();
    write_digit(4'h4, 1'b0);
    write_digit(4'h1, 1'b0);
    write_digit(4'h7, 1'b1);
    write_idle();
    n_checks++;
    if (pending !== 1'b1) $display("FAIL commit_pending: got %b, want 1", pending);
    else n_pass++;
    run_frame(40);
    probe(OX + DW - 1, OY + 5, 1'b1, "slot0_seg_b");
    probe(OX + 8, OY, 1'b0, "slot0_seg_a");
    run_frame(300);
  endtask

  task automatic test_full();
    for (int i = 0; i < NUM; i++) write_digit(4'($urandom_range(0, 9)), 1'b0);
    write_digit(4'h8, 1'b1);
    n_checks++;
    if (wr_ready !== 1'b0) $display("FAIL full_ready: got %b, want 0", wr_ready);
    else n_pass++;
    write_idle();
    run_frame(40);
    run_frame(400);
  endtask

  task automatic test_partial();
    write_digit(4'h2, 1'b0);
    write_digit(4'h5, 1'b0);
    write_idle();
    run_frame(40);
    n_checks++;
    if (pending !== 1'b0 || wr_ready !== 1'b1)
      $display("FAIL partial_flags: got ready=%b pending=%b, want 1 0", wr_ready, pending);
    else n_pass++;
    run_frame(200);
    write_digit(4'h8, 1'b1);
    write_idle();
    run_frame(40);
    probe(OX + 3 * PITCH, OY + 1, 1'b0, "slot3_blank");
    probe(OX + 2 * PITCH, OY + 1, 1'b1, "slot2_eight");
    run_frame(300);
  endtask

  task automatic test_dash_blank();
    write_digit(4'hF, 1'b1);
    write_idle();
    run_frame(40);
    probe(OX + 5, OY + HH - 1, 1'b1, "dash_g");
    probe(OX + 5, OY + 1, 1'b0, "dash_top");
    probe(OX, OY + 5, 1'b0, "dash_left");
    run_frame(200);
    write_digit(4'hB, 1'b1);
    write_idle();
    run_frame(40);
    probe(OX + 5, OY + HH - 1, 1'b0, "blank_g");
    run_frame(200);
  endtask

  task automatic test_reset_mid();
    write_digit(4'h8, 1'b0);
    write_digit(4'h8, 1'b1);
    write_idle();
    for (int i = 0; i < 5; i++) drive_pixel(OX + i, OY + 1, 1'b1, 1'b0, 1'b1, 24'h123456);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_data, o_x, o_y, o_hs, o_vs, o_de} !== '0 || wr_ready !== 1'b1 || pending !== 1'b0)
      $display("FAIL midreset_state: got data=%h ready=%b pending=%b, want 0 1 0",
               o_data, wr_ready, pending);
    else n_pass++;
    i_x = '0; i_y = '0; i_de = 1'b0; i_hs = 1'b0; i_vs = 1'b0; i_data = '0;
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    probe(OX + DW - 1, OY + 5, 1'b0, "after_reset_blank");
    run_frame(300);
  endtask

  task automatic test_back_to_back();
    int len;
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, NUM);
      for (int i = 0; i < len; i++)
        write_digit(4'($urandom), (i == len - 1) && (len < NUM || $urandom_range(0, 1) == 1));
      write_idle();
      run_frame(40);
      run_frame(250);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_commit();
    test_full();
    test_partial();
    test_dash_blank();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
